// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and flush/hold control.
// Ports: clk_i, rst_i (sync, active-high), hold_i, flush_i, id_*_i decoder/regfile inputs,
//   ex_*_o registered EX copies, ex_dst_o registered destination, stall_o combinational.
// Macro ID_EX_STATS_EN adds saturating bubble_cnt_o / flush_cnt_o statistics counters.
module id_ex_stage_reg #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hold_i,
  input  logic          flush_i,
  input  logic [3:0]    id_aluop_i,
  input  logic          id_alusrc_i,
  input  logic          id_regdst_i,
  input  logic          id_regwrite_i,
  input  logic          id_writemem_i,
  input  logic          id_readmem_i,
  input  logic          id_memtoreg_i,
  input  logic [1:0]    id_shift_i,
  input  logic          id_branch_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [DW-1:0] id_pc_plus4_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic [RW-1:0] id_rd_i,
  input  logic [RW-1:0] id_shamt_i,
  output logic [3:0]    ex_aluop_o,
  output logic          ex_alusrc_o,
  output logic          ex_regdst_o,
  output logic          ex_regwrite_o,
  output logic          ex_writemem_o,
  output logic          ex_readmem_o,
  output logic          ex_memtoreg_o,
  output logic [1:0]    ex_shift_o,
  output logic [DW-1:0] ex_rs_data_o,
  output logic [DW-1:0] ex_rt_data_o,
  output logic [DW-1:0] ex_imm_o,
  output logic [DW-1:0] ex_pc_plus4_o,
  output logic [RW-1:0] ex_rs_o,
  output logic [RW-1:0] ex_rt_o,
  output logic [RW-1:0] ex_shamt_o,
  output logic [RW-1:0] ex_dst_o,
`ifdef ID_EX_STATS_EN
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic          stall_o
);

  typedef struct packed {
    logic [3:0] aluop;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       writemem;
    logic       readmem;
    logic       memtoreg;
    logic [1:0] shift;
  } ctrl_t;

  typedef struct packed {
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc_plus4;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] shamt;
  } data_t;

  ctrl_t         id_ctrl, ctrl_q, ctrl_d;
  data_t         id_data, data_q, data_d;
  logic [RW-1:0] id_dst, dst_q, dst_d;
  logic          uses_rs, uses_rt;
  logic          hit_rs, hit_rt;
  logic          stall;

  assign id_ctrl = '{
    aluop:    id_aluop_i,
    alusrc:   id_alusrc_i,
    regdst:   id_regdst_i,
    regwrite: id_regwrite_i,
    writemem: id_writemem_i,
    readmem:  id_readmem_i,
    memtoreg: id_memtoreg_i,
    shift:    id_shift_i
  };

  assign id_data = '{
    rs_data:  id_rs_data_i,
    rt_data:  id_rt_data_i,
    imm:      id_imm_i,
    pc_plus4: id_pc_plus4_i,
    rs:       id_rs_i,
    rt:       id_rt_i,
    shamt:    id_shamt_i
  };

  assign id_dst = id_regdst_i ? id_rd_i : id_rt_i;

  // Shift/LUI forms take no rs operand; immediate ALU ops
  // only read rt when it is store data or a branch compare.
  assign uses_rs = (id_shift_i == 2'b00);
  assign uses_rt = ~id_alusrc_i | id_writemem_i | id_branch_i;

  assign hit_rs = uses_rs & (dst_q == id_rs_i);
  assign hit_rt = uses_rt & (dst_q == id_rt_i);

  assign stall = ctrl_q.readmem & ctrl_q.regwrite &
                 (dst_q != '0) & ~flush_i &
                 (hit_rs | hit_rt);

  assign stall_o = stall;

  // Flush and bubble both zero control only; data is don't-care
  // there, so it is loaded to keep the data path mux-free.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    dst_d  = dst_q;
    if (flush_i) begin
      ctrl_d = '0;
      data_d = id_data;
      dst_d  = id_dst;
    end else if (hold_i) begin
      ctrl_d = ctrl_q;
    end else if (stall) begin
      ctrl_d = '0;
      data_d = id_data;
      dst_d  = id_dst;
    end else begin
      ctrl_d = id_ctrl;
      data_d = id_data;
      dst_d  = id_dst;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      data_q <= '0;
      dst_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      dst_q  <= dst_d;
    end
  end

  assign ex_aluop_o    = ctrl_q.aluop;
  assign ex_alusrc_o   = ctrl_q.alusrc;
  assign ex_regdst_o   = ctrl_q.regdst;
  assign ex_regwrite_o = ctrl_q.regwrite;
  assign ex_writemem_o = ctrl_q.writemem;
  assign ex_readmem_o  = ctrl_q.readmem;
  assign ex_memtoreg_o = ctrl_q.memtoreg;
  assign ex_shift_o    = ctrl_q.shift;
  assign ex_rs_data_o  = data_q.rs_data;
  assign ex_rt_data_o  = data_q.rt_data;
  assign ex_imm_o      = data_q.imm;
  assign ex_pc_plus4_o = data_q.pc_plus4;
  assign ex_rs_o       = data_q.rs;
  assign ex_rt_o       = data_q.rt;
  assign ex_shamt_o    = data_q.shamt;
  assign ex_dst_o      = dst_q;

`ifdef ID_EX_STATS_EN
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    fcnt_d = fcnt_q;
    if (stall && !hold_i && !flush_i && bcnt_q != '1)
      bcnt_d = bcnt_q + ONE;
    if (flush_i && fcnt_q != '1)
      fcnt_d = fcnt_q + ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign bubble_cnt_o = bcnt_q;
  assign flush_cnt_o  = fcnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: vector table with expected EX state
// queued at drive time and compared after the capturing edge.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 8;

  localparam logic [2:0] RUN = 3'b000;
  localparam logic [2:0] RST = 3'b100;
  localparam logic [2:0] HLD = 3'b010;
  localparam logic [2:0] FL  = 3'b001;

  // flag order: alusrc regdst regwrite writemem readmem memtoreg
  localparam logic [5:0] F_ADD = 6'b011000;
  localparam logic [5:0] F_LW  = 6'b101011;
  localparam logic [5:0] F_LUI = 6'b101000;
  localparam logic [5:0] F_SW  = 6'b100100;
  localparam logic [5:0] F_BR  = 6'b100000;

  localparam logic [11:0] C_ADD = {4'h2, F_ADD, 2'b00};
  localparam logic [11:0] C_LW  = {4'h2, F_LW,  2'b00};
  localparam logic [11:0] C_LUI = {4'h5, F_LUI, 2'b10};
  localparam logic [11:0] C_SW  = {4'h2, F_SW,  2'b00};
  localparam logic [11:0] C_BR  = {4'h1, F_BR,  2'b00};

  typedef struct {
    logic [2:0]  rhf;
    logic [3:0]  op;
    logic [5:0]  fl;
    logic [1:0]  sh;
    logic        br;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d;
    logic        cs;
    logic        xs;
    logic [11:0] xc;
    logic [4:0]  xd;
    int          src;
  } vec_t;

  typedef struct {
    logic [11:0] xc;
    logic [4:0]  xd;
    int          src;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst, hold, flush;
  logic [3:0] aluop;
  logic alusrc, regdst, regwrite, writemem, readmem, memtoreg;
  logic [1:0] shift;
  logic branch;
  logic [DW-1:0] rs_data, rt_data, imm, pc4;
  logic [RW-1:0] rs, rt, rd, shamt;
  logic [3:0] ex_aluop;
  logic ex_alusrc, ex_regdst, ex_regwrite, ex_writemem, ex_readmem, ex_memtoreg;
  logic [1:0] ex_shift;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [RW-1:0] ex_rs, ex_rt, ex_shamt, ex_dst;
  logic stall;
`ifdef ID_EX_STATS_EN
  logic [CW-1:0] bubble_cnt, flush_cnt;
`endif

  int errors = 0;
  int checks = 0;
  vec_t tbl[29];
  exp_t q[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DW(DW), .RW(RW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .id_aluop_i(aluop), .id_alusrc_i(alusrc), .id_regdst_i(regdst),
    .id_regwrite_i(regwrite), .id_writemem_i(writemem),
    .id_readmem_i(readmem), .id_memtoreg_i(memtoreg),
    .id_shift_i(shift), .id_branch_i(branch),
    .id_rs_data_i(rs_data), .id_rt_data_i(rt_data),
    .id_imm_i(imm), .id_pc_plus4_i(pc4),
    .id_rs_i(rs), .id_rt_i(rt), .id_rd_i(rd), .id_shamt_i(shamt),
    .ex_aluop_o(ex_aluop), .ex_alusrc_o(ex_alusrc), .ex_regdst_o(ex_regdst),
    .ex_regwrite_o(ex_regwrite), .ex_writemem_o(ex_writemem),
    .ex_readmem_o(ex_readmem), .ex_memtoreg_o(ex_memtoreg),
    .ex_shift_o(ex_shift),
    .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data),
    .ex_imm_o(ex_imm), .ex_pc_plus4_o(ex_pc4),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_shamt_o(ex_shamt),
    .ex_dst_o(ex_dst),
`ifdef ID_EX_STATS_EN
    .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt),
`endif
    .stall_o(stall)
  );

  function automatic vec_t mk(
    logic [2:0] rhf, logic [3:0] op, logic [5:0] fl, logic [1:0] sh,
    logic br, logic [4:0] r_s, logic [4:0] r_t, logic [4:0] r_d,
    logic [31:0] d, logic cs, logic xs, logic [11:0] xc,
    logic [4:0] xd, int src);
    vec_t v;
    v.rhf = rhf; v.op = op; v.fl = fl; v.sh = sh; v.br = br;
    v.rs = r_s; v.rt = r_t; v.rd = r_d; v.d = d;
    v.cs = cs; v.xs = xs; v.xc = xc; v.xd = xd; v.src = src;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    {rst, hold, flush} = v.rhf;
    aluop = v.op;
    {alusrc, regdst, regwrite, writemem, readmem, memtoreg} = v.fl;
    shift = v.sh;
    branch = v.br;
    rs = v.rs; rt = v.rt; rd = v.rd;
    rs_data = v.d;
    rt_data = ~v.d;
    imm = v.d + 32'd1;
    pc4 = v.d << 2;
    shamt = v.rd ^ 5'd1;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_ex(input exp_t e);
    logic [11:0] ctl;
    vec_t s;
    ctl = {ex_aluop, ex_alusrc, ex_regdst, ex_regwrite, ex_writemem,
           ex_readmem, ex_memtoreg, ex_shift};
    chk("ctrl", e.idx, 32'(ctl), 32'(e.xc));
    if (e.src == -2) begin
      chk("dst0", e.idx, 32'(ex_dst), 32'd0);
      chk("data0", e.idx,
          ex_rs_data | ex_rt_data | ex_imm | ex_pc4, 32'd0);
      chk("fld0", e.idx, 32'({ex_rs, ex_rt, ex_shamt}), 32'd0);
    end else if (e.src >= 0) begin
      s = tbl[e.src];
      chk("dst", e.idx, 32'(ex_dst), 32'(e.xd));
      chk("rs_data", e.idx, ex_rs_data, s.d);
      chk("rt_data", e.idx, ex_rt_data, ~s.d);
      chk("imm", e.idx, ex_imm, s.d + 32'd1);
      chk("pc4", e.idx, ex_pc4, s.d << 2);
      chk("rs", e.idx, 32'(ex_rs), 32'(s.rs));
      chk("rt", e.idx, 32'(ex_rt), 32'(s.rt));
      chk("shamt", e.idx, 32'(ex_shamt), 32'(s.rd ^ 5'd1));
    end
  endtask

  initial begin
    exp_t e;
    drive(mk(RUN, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));

    tbl[0]  = mk(RST, 2, F_ADD, 0, 0, 1, 3, 5, $urandom, 0, 0, 0, 0, -2);
    tbl[1]  = mk(RST, 2, F_LW,  0, 0, 2, 8, 0, $urandom, 1, 0, 0, 0, -2);
    tbl[2]  = mk(RUN, 2, F_ADD, 0, 0, 1, 3, 5, 'h1234, 1, 0, C_ADD, 5, 2);
    tbl[3]  = mk(RUN, 2, F_LW,  0, 0, 2, 8, 0, 'h40, 1, 0, C_LW, 8, 3);
    tbl[4]  = mk(RUN, 2, F_ADD, 0, 0, 8, 3, 6, 'h99, 1, 1, 0, 0, -1);
    tbl[5]  = mk(RUN, 2, F_ADD, 0, 0, 8, 3, 6, 'h99, 1, 0, C_ADD, 6, 5);
    tbl[6]  = mk(RUN, 2, F_LW,  0, 0, 2, 0, 0, 'h44, 1, 0, C_LW, 0, 6);
    tbl[7]  = mk(RUN, 2, F_ADD, 0, 0, 0, 0, 7, 'h55, 1, 0, C_ADD, 7, 7);
    tbl[8]  = mk(RUN, 2, F_LW,  0, 0, 2, 8, 0, 'h48, 1, 0, C_LW, 8, 8);
    tbl[9]  = mk(RUN, 5, F_LUI, 2, 0, 8, 8, 0, 'h5000, 1, 0, C_LUI, 8, 9);
    tbl[10] = mk(RUN, 2, F_LW,  0, 0, 2, 8, 0, 'h4c, 1, 0, C_LW, 8, 10);
    tbl[11] = mk(FL,  2, F_ADD, 0, 0, 8, 3, 6, 'h77, 1, 0, 0, 0, -1);
    tbl[12] = mk(RUN, 2, F_LW,  0, 0, 2, 8, 0, 'h50, 1, 0, C_LW, 8, 12);
    tbl[13] = mk(HLD | FL, 2, F_ADD, 0, 0, 8, 3, 6, 'h78, 1, 0, 0, 0, -1);
    tbl[14] = mk(RUN, 2, F_LW,  0, 0, 2, 8, 0, 'h54, 1, 0, C_LW, 8, 14);
    tbl[15] = mk(HLD, 2, F_ADD, 0, 0, 1, 3, 5, 'h11, 1, 0, C_LW, 8, 14);
    tbl[16] = mk(HLD, 3, F_ADD, 0, 0, 4, 4, 9, 'h22, 1, 0, C_LW, 8, 14);
    tbl[17] = mk(HLD, 2, F_ADD, 0, 0, 8, 3, 6, 'h33, 1, 1, C_LW, 8, 14);
    tbl[18] = mk(RUN, 2, F_ADD, 0, 0, 8, 3, 6, 'h99, 1, 1, 0, 0, -1);
    tbl[19] = mk(RUN, 2, F_ADD, 0, 0, 8, 3, 6, 'h99, 1, 0, C_ADD, 6, 19);
    tbl[20] = mk(RUN, 2, F_LW,  0, 0, 2, 8, 0, 'h58, 1, 0, C_LW, 8, 20);
    tbl[21] = mk(RST, 2, F_ADD, 0, 0, 8, 3, 6, 'h99, 1, 1, 0, 0, -2);
    tbl[22] = mk(RUN, 2, F_ADD, 0, 0, 8, 3, 6, 'h9a, 1, 0, C_ADD, 6, 22);
    tbl[23] = mk(RUN, 2, F_LW,  0, 0, 2, 8, 0, 'h5c, 1, 0, C_LW, 8, 23);
    tbl[24] = mk(RUN, 2, F_SW,  0, 0, 2, 8, 0, 'h66, 1, 1, 0, 0, -1);
    tbl[25] = mk(RUN, 2, F_SW,  0, 0, 2, 8, 0, 'h66, 1, 0, C_SW, 8, 25);
    tbl[26] = mk(RUN, 2, F_LW,  0, 0, 2, 9, 0, 'h60, 1, 0, C_LW, 9, 26);
    tbl[27] = mk(RUN, 1, F_BR,  0, 1, 1, 9, 0, 'h70, 1, 1, 0, 0, -1);
    tbl[28] = mk(RUN, 1, F_BR,  0, 1, 1, 9, 0, 'h70, 1, 0, C_BR, 9, 28);

    @(posedge clk);
    #1;
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i]);
      #1;
      if (tbl[i].cs)
        chk("stall", i, 32'(stall), 32'(tbl[i].xs));
      e.xc = tbl[i].xc;
      e.xd = tbl[i].xd;
      e.src = tbl[i].src;
      e.idx = i;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard vec%0d got=empty want=entry", i);
      end else begin
        chk_ex(q.pop_front());
      end
    end

`ifdef ID_EX_STATS_EN
    drive(mk(RST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
    @(posedge clk);
    #1;
    chk("bcnt_rst", 0, 32'(bubble_cnt), 32'd0);
    chk("fcnt_rst", 0, 32'(flush_cnt), 32'd0);
    for (int k = 0; k < 300; k++) begin
      drive(mk(RUN, 2, F_LW, 0, 0, 2, 8, 0, 'h1, 0, 0, 0, 0, -1));
      @(posedge clk);
      #1;
      drive(mk(RUN, 2, F_ADD, 0, 0, 8, 3, 6, 'h2, 0, 0, 0, 0, -1));
      @(posedge clk);
      #1;
    end
    chk("bcnt_sat", 0, 32'(bubble_cnt), 32'd255);
    for (int k = 0; k < 3; k++) begin
      drive(mk(FL, 2, F_ADD, 0, 0, 1, 3, 5, 'h3, 0, 0, 0, 0, -1));
      @(posedge clk);
      #1;
    end
    chk("fcnt", 0, 32'(flush_cnt), 32'd3);
    chk("bcnt_keep", 0, 32'(bubble_cnt), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
